// File: rtl/lift_shaft_model.sv
// rtl/lift_shaft_model.sv - plant model of lift car, doors and shaft driven by the lift controller's motor outputs
module lift_shaft_model #(
    parameter int DOOR_CYCLES = 4,
    parameter int STEP_CYCLES = 8,
    parameter int TOP_POS     = 3,
    parameter int PW          = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          motor_on,
    input  logic          motor_direction,
    output logic          doors_closed,
    output logic          top_floor,
    output logic          ground_floor,
    output logic [PW-1:0] position,
    output logic [1:0]    door_state,
    output logic          moving,
    output logic          overtravel_fault
);

    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam int SCW = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {
        OPEN    = 2'd0,
        CLOSING = 2'd1,
        CLOSED  = 2'd2,
        OPENING = 2'd3
    } door_t;

    door_t           door;
    logic [DCW-1:0]  door_cnt;
    logic [SCW-1:0]  step_cnt;
    logic [PW-1:0]   pos;
    logic            fault;

    logic at_top, at_ground, step_due, blocked, travel, stroke_done;

    assign at_top      = (pos == PW'(TOP_POS));
    assign at_ground   = (pos == '0);
    assign step_due    = (step_cnt == SCW'(STEP_CYCLES - 1));
    assign blocked     = motor_direction ? at_top : at_ground;
    assign travel      = (door == CLOSED) && motor_on;
    assign stroke_done = (door_cnt == DCW'(DOOR_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            door     <= OPEN;
            door_cnt <= '0;
            step_cnt <= '0;
            pos      <= '0;
            fault    <= 1'b0;
        end else begin
            // A step boundary that would leave the shaft is swallowed and latched as a fault.
            if (travel) begin
                if (step_due) begin
                    step_cnt <= '0;
                    if (blocked)
                        fault <= 1'b1;
                    else if (motor_direction)
                        pos <= pos + PW'(1);
                    else
                        pos <= pos - PW'(1);
                end else begin
                    step_cnt <= step_cnt + SCW'(1);
                end
            end else begin
                step_cnt <= '0;
            end

            case (door)
                OPEN: begin
                    if (motor_on) begin
                        door     <= CLOSING;
                        door_cnt <= '0;
                    end
                end
                CLOSING: begin
                    if (!motor_on)
                        door <= OPEN;
                    else if (stroke_done)
                        door <= CLOSED;
                    else
                        door_cnt <= door_cnt + DCW'(1);
                end
                CLOSED: begin
                    if (!motor_on && (at_top || at_ground)) begin
                        door     <= OPENING;
                        door_cnt <= '0;
                    end
                end
                OPENING: begin
                    if (motor_on) begin
                        door     <= CLOSING;
                        door_cnt <= '0;
                    end else if (stroke_done) begin
                        door <= OPEN;
                    end else begin
                        door_cnt <= door_cnt + DCW'(1);
                    end
                end
                default: door <= OPEN;
            endcase
        end
    end

    assign position         = pos;
    assign door_state       = door;
    assign doors_closed     = (door == CLOSED);
    assign top_floor        = at_top;
    assign ground_floor     = at_ground;
    assign overtravel_fault = fault;
    assign moving           = travel && !(step_due && blocked);

endmodule

// File: tb/tb_lift_shaft_model.sv
// tb/tb_lift_shaft_model.sv - table, directed and random checks of lift_shaft_model against a timing-based model
module tb_lift_shaft_model;

    localparam int DC  = 4;
    localparam int SC  = 8;
    localparam int TOP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       motor_on;
    logic       motor_direction;
    logic       doors_closed;
    logic       top_floor;
    logic       ground_floor;
    logic [1:0] position;
    logic [1:0] door_state;
    logic       moving;
    logic       overtravel_fault;

    lift_shaft_model #(.DOOR_CYCLES(DC), .STEP_CYCLES(SC), .TOP_POS(TOP), .PW(2)) dut (
        .clk(clk),
        .reset(reset),
        .motor_on(motor_on),
        .motor_direction(motor_direction),
        .doors_closed(doors_closed),
        .top_floor(top_floor),
        .ground_floor(ground_floor),
        .position(position),
        .door_state(door_state),
        .moving(moving),
        .overtravel_fault(overtravel_fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: door phase plus the edge index it was entered on; travel as a count of active edges.
    int m_pos, m_door, m_fault, m_enter, m_active, now;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_door = 0; m_fault = 0; m_enter = 0; m_active = 0;
    endtask

    function automatic int exp_moving(input logic on, input logic dir);
        int tgt;
        if (!(on && m_door == 2)) return 0;
        tgt = m_pos + (dir ? 1 : -1);
        if ((m_active + 1) % SC == 0 && (tgt < 0 || tgt > TOP)) return 0;
        return 1;
    endfunction

    task automatic model_edge(input logic on, input logic dir);
        int old_pos, tgt, el;
        old_pos = m_pos;
        el = now - m_enter;
        if (m_door == 2 && on) begin
            m_active++;
            if (m_active % SC == 0) begin
                tgt = m_pos + (dir ? 1 : -1);
                if (tgt < 0 || tgt > TOP) m_fault = 1;
                else m_pos = tgt;
            end
        end else begin
            m_active = 0;
        end
        case (m_door)
            0: if (on) begin m_door = 1; m_enter = now; end
            1: if (!on) m_door = 0; else if (el == DC) m_door = 2;
            2: if (!on && (old_pos == 0 || old_pos == TOP)) begin m_door = 3; m_enter = now; end
            default: if (on) begin m_door = 1; m_enter = now; end else if (el == DC) m_door = 0;
        endcase
        now++;
    endtask

    task automatic check_state();
        chk("position", position, m_pos);
        chk("door_state", door_state, m_door);
        chk("doors_closed", doors_closed, m_door == 2);
        chk("top_floor", top_floor, m_pos == TOP);
        chk("ground_floor", ground_floor, m_pos == 0);
        chk("fault", overtravel_fault, m_fault);
    endtask

    // Called just after a falling edge: apply inputs, check moving, take one rising edge, check state.
    task automatic cycle(input logic on, input logic dir);
        motor_on = on;
        motor_direction = dir;
        #1;
        chk("moving", moving, exp_moving(on, dir));
        @(posedge clk);
        model_edge(on, dir);
        @(negedge clk);
        check_state();
    endtask

    task automatic run(input logic on, input logic dir, input int n);
        for (int i = 0; i < n; i++) cycle(on, dir);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic on;
        logic dir;
        int   n;
        int   pos;
        int   door;
        int   fault;
    } row_t;

    row_t tbl[11];
    bit   saw_closed;

    initial begin
        reset = 1'b1;
        motor_on = 1'b0;
        motor_direction = 1'b0;
        model_reset();
        now = 0;
        repeat (2) @(negedge clk);
        chk("rst_doors_closed", doors_closed, 0);
        chk("rst_ground", ground_floor, 1);
        chk("rst_top", top_floor, 0);
        chk("rst_moving", moving, 0);
        chk("rst_position", position, 0);
        chk("rst_fault", overtravel_fault, 0);
        reset = 1'b0;

        // Full trip up, door reopen at the top, then held drive into the top limit.
        tbl[0]  = '{1'b1, 1'b1, 5, 0, 2, 0};
        tbl[1]  = '{1'b1, 1'b1, 8, 1, 2, 0};
        tbl[2]  = '{1'b1, 1'b1, 8, 2, 2, 0};
        tbl[3]  = '{1'b1, 1'b1, 8, 3, 2, 0};
        tbl[4]  = '{1'b0, 1'b1, 1, 3, 3, 0};
        tbl[5]  = '{1'b0, 1'b1, 4, 3, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 5, 3, 2, 0};
        tbl[7]  = '{1'b1, 1'b1, 7, 3, 2, 0};
        tbl[8]  = '{1'b1, 1'b1, 1, 3, 2, 1};
        tbl[9]  = '{1'b0, 1'b1, 1, 3, 3, 1};
        tbl[10] = '{1'b0, 1'b1, 4, 3, 0, 1};
        for (int r = 0; r < 11; r++) begin
            run(tbl[r].on, tbl[r].dir, tbl[r].n);
            chk($sformatf("tbl%0d_pos", r), position, tbl[r].pos);
            chk($sformatf("tbl%0d_door", r), door_state, tbl[r].door);
            chk($sformatf("tbl%0d_fault", r), overtravel_fault, tbl[r].fault);
        end

        // Blocked boundary: moving low only on the boundary cycle.
        run(1'b1, 1'b1, 12);
        motor_on = 1'b1;
        motor_direction = 1'b1;
        #1;
        chk("limit_moving", moving, 0);
        run(1'b1, 1'b1, 1);
        chk("limit_pos", position, 3);

        // Drive down to position 2 then async reset mid-cycle.
        run(1'b1, 1'b0, 8);
        chk("pre_reset_pos", position, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_pos", position, 0);
        chk("arst_ground", ground_floor, 1);
        chk("arst_closed", doors_closed, 0);
        chk("arst_fault", overtravel_fault, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Abort a close at door_cnt=2, then a full stroke again.
        run(1'b1, 1'b1, 3);
        saw_closed = doors_closed;
        run(1'b0, 1'b1, 1);
        chk("abort_open", door_state, 0);
        chk("abort_never_closed", saw_closed, 0);
        run(1'b1, 1'b1, 4);
        chk("restroke_not_yet", doors_closed, 0);
        run(1'b1, 1'b1, 1);
        chk("restroke_closed", doors_closed, 1);

        // Stop between landings, then reverse.
        run(1'b1, 1'b1, 8);
        chk("mid_pos1", position, 1);
        run(1'b0, 1'b1, 3);
        chk("mid_door", door_state, 2);
        chk("mid_hold", position, 1);
        run(1'b1, 1'b0, 7);
        chk("down_pending", position, 1);
        run(1'b1, 1'b0, 1);
        chk("down_ground", position, 0);
        chk("down_fault", overtravel_fault, 0);

        // Random drive against the model.
        begin
            logic on, dir;
            on = 1'b0;
            dir = 1'b1;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) on = ~on;
                if ($urandom_range(0, 15) == 0) dir = ~dir;
                if ($urandom_range(0, 499) == 0) do_reset();
                cycle(on, dir);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
